sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Transmit-side partner of the team's serial sequence detector.
- Accepts a PAT_W-bit pattern and a repeat count through a start/ready handshake.
- Serialises the pattern MSB-first onto a 1-bit stream `x`, one bit per clock.
- Optional idle gaps go between repetitions; the output drives a detector's `x` input directly in benches and on the FPGA.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 4, width of repeat-count input.
- GAP_LEN, 2, idle (x=0, x_valid=0) cycles between repetitions; 0 allowed.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin transmission.
- pattern  input  PAT_W  bits to send, MSB transmitted first.
- reps  input  CNT_W  number of repetitions; 0 treated as 1.
- ready  output  1  high only in IDLE; start accepted when start&ready.
- x  output  1  serial data bit (registered).
- x_valid  output  1  high when x carries a pattern (or parity) bit.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-cycle pulse after final bit of final repetition.

Behaviour:
- Interface: one clock `clk`; reset `clr_n` is synchronous and active-low.
- Reset (clr_n=0 at a rising edge): state=IDLE, x=0, x_valid=0, busy=0, done=0, ready=1 after the edge, internal counters cleared.
  - Reset mid-transmission aborts immediately; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE:
    - ready=1.
    - On start=1: capture pattern into shift register, rep counter = (reps==0 ? 1 : reps), bit counter = PAT_W-1, go to SEND.
    - start=0: stay.
  - SEND:
    - x=shreg[MSB], x_valid=1, shift left each cycle.
    - When bit counter reaches 0 the last bit is presented. Next state:
      - PAR if PARITY_EN.
      - Else, if more reps remain: GAP (or SEND with pattern reloaded from captured copy if GAP_LEN==0).
      - Else DONE.
  - PAR (PARITY_EN only): one cycle, x=even parity (XOR of captured pattern), x_valid=1; then the same next-state rule as end of SEND.
  - GAP:
    - x=0, x_valid=0 for exactly GAP_LEN cycles.
    - Reload shreg from captured copy, decrement rep counter, then SEND.
  - DONE:
    - done=1 for one cycle, x=0, x_valid=0, busy=1.
    - Then IDLE.
- Latency: first bit appears on x in the cycle after the accepting edge.
- Per repetition: PAT_W cycles (+1 with parity) of x_valid=1.
- Input sampling:
  - pattern and reps are sampled only at acceptance; later changes have no effect on the current transmission.
  - start while busy is ignored (not queued).
  - start asserted in the DONE cycle is ignored; accepted in the following IDLE cycle.
- Rep counter is CNT_W wide.
  - Max repetitions = 2^CNT_W-1.
  - No wrap: decrements stop at 1 → DONE.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined: PAR state compiled in; each repetition is followed by one even-parity bit with x_valid=1 before the gap.
- Undefined: no PAR state, no parity logic; repetition length is exactly PAT_W bits.

Decomposition:
- Shared package `seqgen_pkg`:
  - state encoding typedef (IDLE, SEND, PAR, GAP, DONE).
  - default PAT_W/CNT_W/GAP_LEN constants.
  - even-parity function.
- One natural sub-module, `seqgen_shifter`:
  - loadable PAT_W-bit left shift register with bit counter.
  - ports: load, shift, load value, serial out, last-bit flag.
- FSM and rep/gap counters stay in the top module.

Test Plan:
- Reset hold, then clr_n=1 with start=0 for 5 cycles → x=0, x_valid=0, ready=1, done=0 throughout.
- pattern=4'b1101, reps=1, start one cycle → x=1,1,0,1 with x_valid=1 on cycles 1-4 after accept; done=1 on cycle 5; ready=1 on cycle 6.
- pattern=4'b1011, reps=3, GAP_LEN=2 → three 1011 bursts, each separated by 2 cycles of x_valid=0; single done pulse after the third burst; total 4+2+4+2+4+1 cycles busy.
- reps=0, pattern=4'b0110 → exactly one burst 0110, then done; GAP_LEN=0, reps=2 → 01100110 back-to-back with x_valid continuously high.
- Mid-burst: clr_n=0 at bit 2 → next cycle x=0, x_valid=0, busy=0, no done; start during busy changing pattern → original pattern completes unaltered.
- SEQGEN_PARITY_EN defined, pattern=4'b1101, reps=1 → x=1,1,0,1,1 (parity=1) with x_valid=1 for 5 cycles, then done.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator: state encoding,
// default geometry and the even-parity helper.
// Optional build macro: SEQGEN_PARITY_EN (adds the PAR state).
package seqgen_pkg;

   localparam int DEF_PAT_W   = 4;
   localparam int DEF_CNT_W   = 4;
   localparam int DEF_GAP_LEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
`ifdef SEQGEN_PARITY_EN
      ST_PAR  = 3'd2,
`endif
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Even parity bit: 1 when the word holds an odd number of ones.
   function automatic logic even_parity(input logic [63:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Request/stream bundle between a pattern source and the generator.
//
// Handshake: a request is accepted on the rising clk edge where
// start=1 and ready=1; pattern/reps are captured on that edge only.
// start while ready=0 is dropped, never queued. x_valid qualifies x
// one bit per clock; done pulses once when a request has finished.
interface sequence_generator_if
   import seqgen_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] reps;
   logic             ready;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, reps,
      input  ready, x, x_valid, busy, done
   );

   modport slave (
      input  start, pattern, reps,
      output ready, x, x_valid, busy, done
   );
endinterface

// File: rtl/seqgen_shifter.sv
// Loadable MSB-first serialiser. sout is a register holding the bit
// currently on the line; it drops to 0 in any cycle that neither loads
// nor shifts, so the line is quiet outside bursts.
module seqgen_shifter #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] load_val,
   output logic             sout,
   output logic             last
);
   localparam int CNT_BITS = $clog2(PAT_W);
   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(PAT_W - 1);

   logic [PAT_W-1:0]    rest_q;   // bits still to send, next one at MSB
   logic [CNT_BITS-1:0] cnt_q;    // bits remaining after the one on sout

   assign last = (cnt_q == '0);

   // Present the MSB on load, then step one bit per shift.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         sout   <= 1'b0;
         rest_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         sout   <= load_val[PAT_W-1];
         rest_q <= {load_val[PAT_W-2:0], 1'b0};
         cnt_q  <= CNT_MAX;
      end else if (shift) begin
         sout   <= rest_q[PAT_W-1];
         rest_q <= {rest_q[PAT_W-2:0], 1'b0};
         cnt_q  <= cnt_q - CNT_BITS'(1);
      end else begin
         sout   <= 1'b0;
      end
   end
endmodule

// File: rtl/sequence_generator.sv
// Serial pattern generator: sends a captured pattern MSB-first, reps
// times, with GAP_LEN idle cycles between repetitions, then pulses done.
// Optional build macro: SEQGEN_PARITY_EN appends an even-parity bit to
// every repetition.
module sequence_generator
   import seqgen_pkg::*;
#(
   parameter int PAT_W   = DEF_PAT_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int GAP_LEN = DEF_GAP_LEN
) (
   input  logic                 clk,
   input  logic                 clr_n,
   sequence_generator_if.slave  bus,
   output state_t               dbg_state
);
   localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

   state_t           state_q, state_n;
   logic [PAT_W-1:0] cap_q;      // pattern copy used for reloads
   logic [CNT_W-1:0] rep_q;      // repetitions left, including current
   logic [GAP_W-1:0] gap_q;      // idle cycles left after this one

   logic             sh_load, sh_shift, sh_last, sout;
   logic [PAT_W-1:0] ld_val;
   logic             cap_en, rep_ld, rep_dec, gap_ld, gap_dec, rep_end;

   logic             ready_q, x_valid_q, busy_q, done_q;
`ifdef SEQGEN_PARITY_EN
   logic             par_q;
`endif

   seqgen_shifter #(.PAT_W(PAT_W)) u_shifter (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (sh_load),
      .shift    (sh_shift),
      .load_val (ld_val),
      .sout     (sout),
      .last     (sh_last)
   );

   // Next-state and datapath control; end-of-repetition handled once below.
   always_comb begin
      state_n  = state_q;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      ld_val   = cap_q;
      cap_en   = 1'b0;
      rep_ld   = 1'b0;
      rep_dec  = 1'b0;
      gap_ld   = 1'b0;
      gap_dec  = 1'b0;
      rep_end  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = ST_SEND;
               sh_load = 1'b1;
               ld_val  = bus.pattern;
               cap_en  = 1'b1;
               rep_ld  = 1'b1;
            end
         end
         ST_SEND: begin
            if (!sh_last) begin
               sh_shift = 1'b1;
            end else begin
`ifdef SEQGEN_PARITY_EN
               state_n = ST_PAR;
`else
               rep_end = 1'b1;
`endif
            end
         end
`ifdef SEQGEN_PARITY_EN
         ST_PAR: rep_end = 1'b1;
`endif
         ST_GAP: begin
            if (gap_q == '0) begin
               state_n = ST_SEND;
               sh_load = 1'b1;
            end else begin
               gap_dec = 1'b1;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (rep_end) begin
         if (rep_q > CNT_W'(1)) begin
            rep_dec = 1'b1;
            if (GAP_LEN == 0) begin
               state_n = ST_SEND;
               sh_load = 1'b1;
            end else begin
               state_n = ST_GAP;
               gap_ld  = 1'b1;
            end
         end else begin
            state_n = ST_DONE;
         end
      end
   end

   // State, captured pattern and repetition/gap counters.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_n;
         if (cap_en) cap_q <= bus.pattern;
         if (rep_ld)       rep_q <= (bus.reps == '0) ? CNT_W'(1) : bus.reps;
         else if (rep_dec) rep_q <= rep_q - CNT_W'(1);
         if (gap_ld)       gap_q <= GAP_LAST;
         else if (gap_dec) gap_q <= gap_q - GAP_W'(1);
      end
   end

   // Status outputs registered from the next state so they line up with x.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         ready_q   <= 1'b1;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQGEN_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         ready_q   <= (state_n == ST_IDLE);
         busy_q    <= (state_n != ST_IDLE);
         done_q    <= (state_n == ST_DONE);
`ifdef SEQGEN_PARITY_EN
         x_valid_q <= (state_n == ST_SEND) || (state_n == ST_PAR);
         par_q     <= (state_n == ST_PAR) ? even_parity(64'(cap_q)) : 1'b0;
`else
         x_valid_q <= (state_n == ST_SEND);
`endif
      end
   end

   // Shifter output is zero outside SEND, so the parity flop can be ORed in.
`ifdef SEQGEN_PARITY_EN
   assign bus.x     = sout | par_q;
`else
   assign bus.x     = sout;
`endif
   assign bus.x_valid = x_valid_q;
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign dbg_state   = state_q;
endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: one instance with a 2-cycle gap (a) and
// one with no gap (b). Stimulus pushes the expected per-busy-cycle
// {x_valid, x, done} trace; a negedge monitor pops and compares it.
module tb_sequence_generator;
   import seqgen_pkg::*;

   localparam int PAT_W = 4;
   localparam int CNT_W = 4;
   localparam int GAP_A = 2;
   localparam int GAP_B = 0;
`ifdef SEQGEN_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt_a = 0;
   int   busy_cnt_b = 0;
   logic [2:0] exp_q_a[$];
   logic [2:0] exp_q_b[$];
   state_t dbg_a, dbg_b;

   sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_a ();
   sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_b ();

   sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_A)) u_dut_a (
      .clk(clk), .clr_n(clr_n), .bus(bus_a), .dbg_state(dbg_a));
   sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_B)) u_dut_b (
      .clk(clk), .clr_n(clr_n), .bus(bus_b), .dbg_state(dbg_b));

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic get_ready(input int idx);
      return (idx == 0) ? bus_a.ready : bus_b.ready;
   endfunction

   function automatic logic get_busy(input int idx);
      return (idx == 0) ? bus_a.busy : bus_b.busy;
   endfunction

   function automatic int qsize(input int idx);
      return (idx == 0) ? exp_q_a.size() : exp_q_b.size();
   endfunction

   function automatic int exp_len(input int idx, input int reps);
      int n   = (reps == 0) ? 1 : reps;
      int gap = (idx == 0) ? GAP_A : GAP_B;
      return n * (PAT_W + PAR_BITS) + (n - 1) * gap + 1;
   endfunction

   task automatic push(input int idx, input logic [2:0] e);
      if (idx == 0) exp_q_a.push_back(e);
      else          exp_q_b.push_back(e);
   endtask

   // Expected trace entries: {x_valid, x, done}, one per busy cycle.
   task automatic push_trace(input int idx, input logic [PAT_W-1:0] pat, input int reps);
      int n   = (reps == 0) ? 1 : reps;
      int gap = (idx == 0) ? GAP_A : GAP_B;
      for (int r = 0; r < n; r++) begin
         for (int b = PAT_W - 1; b >= 0; b--) push(idx, {1'b1, pat[b], 1'b0});
         if (PAR_BITS == 1) push(idx, {1'b1, ^pat, 1'b0});
         if (r < n - 1) for (int g = 0; g < gap; g++) push(idx, 3'b000);
      end
      push(idx, 3'b001);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int idx, input logic st, input logic [PAT_W-1:0] pat,
                        input logic [CNT_W-1:0] rp);
      if (idx == 0) begin
         bus_a.start = st; bus_a.pattern = pat; bus_a.reps = rp;
      end else begin
         bus_b.start = st; bus_b.pattern = pat; bus_b.reps = rp;
      end
   endtask

   task automatic send(input int idx, input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rp);
      int t = 0;
      while (!get_ready(idx) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("ready_before_start", get_ready(idx), 1);
      if (idx == 0) busy_cnt_a = 0;
      else          busy_cnt_b = 0;
      push_trace(idx, pat, int'(rp));
      drive(idx, 1'b1, pat, rp);
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the burst must not notice.
      drive(idx, 1'b0, ~pat, rp + CNT_W'(3));
   endtask

   task automatic wait_idle(input int idx, input int len);
      int t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while ((get_busy(idx) || qsize(idx) != 0) && t < 400);
      check("drain_queue_empty", qsize(idx), 0);
      check("busy_len", (idx == 0) ? busy_cnt_a : busy_cnt_b, len);
      check("ready_after_done", get_ready(idx), 1);
   endtask

   // ---------------- scoreboard monitor ----------------
   task automatic check_port(input int idx, input logic busy, input logic [2:0] got);
      logic [2:0] e;
      if (busy) begin
         if (idx == 0) busy_cnt_a++;
         else          busy_cnt_b++;
         if (qsize(idx) == 0) begin
            check((idx == 0) ? "a_unexpected_busy" : "b_unexpected_busy", 1, 0);
         end else begin
            if (idx == 0) e = exp_q_a.pop_front();
            else          e = exp_q_b.pop_front();
            check((idx == 0) ? "a_stream" : "b_stream", got, e);
         end
      end else begin
         check((idx == 0) ? "a_idle_out" : "b_idle_out", got, 3'b000);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check_port(0, bus_a.busy, {bus_a.x_valid, bus_a.x, bus_a.done});
         check_port(1, bus_b.busy, {bus_b.x_valid, bus_b.x, bus_b.done});
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      drive(0, 1'b0, '0, '0);
      drive(1, 1'b0, '0, '0);
      repeat (3) begin @(posedge clk); #1; end
      mon_en = 1'b1;
      clr_n  = 1'b1;

      // Idle after reset: ready high, nothing on the line.
      for (int i = 0; i < 5; i++) begin
         check("reset_ready_a", bus_a.ready, 1);
         check("reset_ready_b", bus_b.ready, 1);
         check("reset_busy_a", bus_a.busy, 0);
         check("reset_state_a", dbg_a, ST_IDLE);
         @(posedge clk); #1;
      end

      // Single burst, then 3 bursts with gaps, then reps=0 as one burst.
      send(0, 4'b1101, 4'd1);  wait_idle(0, exp_len(0, 1));
      send(0, 4'b1011, 4'd3);  wait_idle(0, exp_len(0, 3));
      send(0, 4'b0110, 4'd0);  wait_idle(0, exp_len(0, 0));

      // No gap: 0110 0110 back-to-back; max repetition count.
      send(1, 4'b0110, 4'd2);  wait_idle(1, exp_len(1, 2));
      send(1, 4'b1010, 4'd15); wait_idle(1, exp_len(1, 15));

      // start while busy with a different pattern is dropped.
      send(0, 4'b1011, 4'd2);
      @(posedge clk); #1;
      drive(0, 1'b1, 4'b0000, 4'd7);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'b0000, 4'd7);
      wait_idle(0, exp_len(0, 2));

      // start raised in the DONE cycle is taken in the following IDLE cycle.
      send(0, 4'b1101, 4'd1);
      for (int t = 0; t < 20 && !bus_a.done; t++) begin @(posedge clk); #1; end
      check("done_seen", bus_a.done, 1);
      push_trace(0, 4'b0011, 1);
      drive(0, 1'b1, 4'b0011, 4'd1);
      @(posedge clk); #1;
      check("idle_after_done_ready", bus_a.ready, 1);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'b0000, 4'd0);
      wait_idle(0, exp_len(0, 1) * 2);

      // Reset in the middle of a burst aborts with no done pulse.
      send(0, 4'b1011, 4'd1);
      @(posedge clk); #1;
      clr_n = 1'b0;
      @(posedge clk); #1;
      exp_q_a.delete();
      check("abort_busy", bus_a.busy, 0);
      check("abort_x_valid", bus_a.x_valid, 0);
      check("abort_x", bus_a.x, 0);
      check("abort_done", bus_a.done, 0);
      check("abort_ready", bus_a.ready, 1);
      check("abort_state", dbg_a, ST_IDLE);
      clr_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end

      // Recovery after the abort.
      send(0, 4'b1001, 4'd1);  wait_idle(0, exp_len(0, 1));

      repeat (3) begin @(posedge clk); #1; end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
